// File: rtl/simon_sequencer_pkg.sv
// ============================================================================
// simon_pkg : shared arrow codes, FSM states and LFSR step for simon_sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package simon_pkg;

  localparam logic [2:0] DIR_UP    = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_NONE  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPEND   = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  // Fibonacci LFSR, taps 8,6,5,4, feedback shifted in at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_sequencer_if.sv
// ============================================================================
// simon_sequencer_if : player-input / display-side signals of simon_sequencer
// Revision           : 1.0
// ============================================================================
`default_nettype none

interface simon_sequencer_if;
  logic       start;
  logic [2:0] dir_in;
  logic [2:0] display_dir;
  logic       show_active;
  logic       input_active;
  logic [5:0] level;
  logic       win;
  logic       game_over;

  modport master (
    output start, dir_in,
    input  display_dir, show_active, input_active, level, win, game_over
  );

  modport slave (
    input  start, dir_in,
    output display_dir, show_active, input_active, level, win, game_over
  );
endinterface

`default_nettype wire

// File: rtl/simon_sequencer_seq_mem.sv
// ============================================================================
// simon_seq_mem : MAX_LEN x 2-bit arrow store, sync write, comb read (3-bit out)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module simon_seq_mem #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  wire logic          clock_i,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [1:0]    wdata_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [2:0]    rdata_o
);

  localparam logic [AW:0] c_depth = (AW+1)'(MAX_LEN);

  logic [1:0] mem_q [MAX_LEN];

  always_ff @(posedge clock_i) begin
    if (we_i && ({1'b0, waddr_i} < c_depth)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the 2-bit direction is kept; the MSB of a stored arrow is always 0.
  always_comb begin
    rdata_o = 3'b000;
    if ({1'b0, raddr_i} < c_depth) begin
      rdata_o = {1'b0, mem_q[raddr_i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/simon_sequencer.sv
// ============================================================================
// simon_sequencer : Simon Says game FSM - grows, plays back and checks sequence
// Revision        : 1.0
// ============================================================================
`default_nettype none

module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned SHOW_CYCLES    = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input wire logic          clock,
  input wire logic          reset,
  simon_sequencer_if.slave  bus
);

  localparam int unsigned MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] c_show_load = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tmo_load  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]       c_max_len   = 6'(MAX_LEN);

  state_e           state_q, state_d;
  logic [7:0]       lfsr_q;
  logic [5:0]       level_q, level_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dir_q, dir_prev_q;
  logic [2:0]       display_dir_q, display_dir_d;
  logic             show_active_q, show_active_d;
  logic             input_active_q, input_active_d;
  logic             win_q, win_d;
  logic             game_over_q, game_over_d;

  logic             w_we;
  logic [IDX_W-1:0] w_raddr;
  logic [2:0]       w_rdata;
  logic [2:0]       w_show_dir;
  logic             w_press;
  logic             w_last;

  // The read address anticipates the arrow needed in the next cycle so that
  // display_dir can be registered; in INPUT it points at the expected arrow.
  assign w_raddr = (state_q == ST_SHOW_OFF) ? idx_q + 1'b1 :
                   (state_q == ST_APPEND)   ? '0           : idx_q;

  simon_seq_mem #(.MAX_LEN(MAX_LEN), .AW(IDX_W)) u_mem (
    .clock_i (clock),
    .we_i    (w_we),
    .waddr_i (level_q[IDX_W-1:0]),
    .wdata_i (lfsr_q[1:0]),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata)
  );

  // seq[0] is written on the same edge the first arrow is shown: bypass it.
  assign w_show_dir = (state_q == ST_APPEND && level_q == 6'd0) ? {1'b0, lfsr_q[1:0]} : w_rdata;
  assign w_press    = (dir_q != DIR_NONE) && (dir_prev_q == DIR_NONE);
  assign w_last     = (6'(idx_q) == level_q - 6'd1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    w_we    = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          level_d = 6'd0;
          state_d = ST_APPEND;
        end
      end
      ST_APPEND: begin
        w_we    = 1'b1;
        level_d = level_q + 6'd1;
        idx_d   = '0;
        cnt_d   = c_show_load;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = c_gap_load;
          state_d = ST_SHOW_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (cnt_q == '0) begin
          if (w_last) begin
            idx_d   = '0;
            cnt_d   = c_tmo_load;
            state_d = ST_INPUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = c_show_load;
            state_d = ST_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_INPUT: begin
        if (w_press) begin
          if (dir_q != w_rdata) begin
            state_d = ST_LOSE;
          end else if (!w_last) begin
            idx_d = idx_q + 1'b1;
            cnt_d = c_tmo_load;
          end else if (level_q == c_max_len) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_APPEND;
          end
        end else if (cnt_q == '0) begin
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    display_dir_d  = DIR_NONE;
    show_active_d  = 1'b0;
    input_active_d = 1'b0;
    win_d          = 1'b0;
    game_over_d    = 1'b0;
    case (state_d)
      ST_SHOW_ON: begin
        display_dir_d = w_show_dir;
        show_active_d = 1'b1;
      end
      ST_SHOW_OFF: show_active_d = 1'b1;
      ST_INPUT: begin
        display_dir_d  = bus.dir_in;
        input_active_d = 1'b1;
      end
      ST_WIN:  win_d       = 1'b1;
      ST_LOSE: game_over_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lfsr_q         <= SEED;
      level_q        <= 6'd0;
      idx_q          <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_NONE;
      dir_prev_q     <= DIR_NONE;
      display_dir_q  <= DIR_NONE;
      show_active_q  <= 1'b0;
      input_active_q <= 1'b0;
      win_q          <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_next(lfsr_q);
      level_q        <= level_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      dir_q          <= bus.dir_in;
      dir_prev_q     <= dir_q;
      display_dir_q  <= display_dir_d;
      show_active_q  <= show_active_d;
      input_active_q <= input_active_d;
      win_q          <= win_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.display_dir  = display_dir_q;
  assign bus.show_active  = show_active_q;
  assign bus.input_active = input_active_q;
  assign bus.level        = level_q;
  assign bus.win          = win_q;
  assign bus.game_over    = game_over_q;

endmodule

`default_nettype wire
